// File: rtl/rom_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_loader_pkg                                                        |
// | Shared constants for the boot ROM loader: state codes, frame field    |
// | size and byte-index width.                                            |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package rom_loader_pkg;

  // Header and checksum fields are each one 32-bit word, sent as 4 bytes.
  localparam int FIELD_BYTES = 4;
  localparam int BYTE_IDX_W  = 2;

  // Loader state codes.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // A frame is in progress in LEN, DATA and CSUM.
  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_loader_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_packer                                                           |
// | Little-endian 4-byte to 32-bit word assembler. The completed word and |
// | its word_valid strobe are presented combinationally in the cycle the  |
// | 4th byte arrives so the owner can register the result one cycle later.|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module byte_packer
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FIELD_BYTES - 1);

  logic [BYTE_IDX_W-1:0] r_idx;
  logic [23:0]           r_hold;

  // Byte index: advances per byte, wraps 3->0 at each completed word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_idx <= '0;
    end else if (byte_valid) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Hold the lower three bytes until the top byte completes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (byte_valid && !clear) begin
      case (r_idx)
        2'd0:    r_hold[7:0]   <= byte_in;
        2'd1:    r_hold[15:8]  <= byte_in;
        2'd2:    r_hold[23:16] <= byte_in;
        default: r_hold        <= r_hold;
      endcase
    end
  end

  assign word       = {byte_in, r_hold};
  assign word_valid = byte_valid && !clear && (r_idx == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_loader                                                            |
// | Boot-time ROM write initiator: receives a framed byte stream (length, |
// | payload words, checksum), writes each word to the ROM, holds the CPU  |
// | in reset while loading and reports done or error.                     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_hold_o,
  output logic [31:0] word_cnt_o
);

  localparam logic [31:0] DEPTH_W      = 32'(DEPTH);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [31:0] r_len;
  logic [31:0] r_sum;
  logic [31:0] r_next_addr;
  logic [31:0] r_word_cnt;
  logic [31:0] r_to_cnt;
  logic        r_cpu_hold;

  logic        w_busy;
  logic        w_accept;
  logic        w_start;
  logic        w_timeout;
  logic        w_clear;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic        w_len_ok;
  logic        w_data_word;
  logic        w_last_word;
  logic        w_csum_ok;

  assign w_busy    = is_busy(r_state);
  assign w_accept  = w_busy && byte_valid_i;
  assign w_start   = !w_busy && start_i;
  // An accepted byte in the expiry cycle wins over the timeout.
  assign w_timeout = w_busy && !byte_valid_i && (r_to_cnt == TIMEOUT_LAST);
  // Start and timeout both discard any partially assembled word.
  assign w_clear   = w_start || w_timeout;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_clear),
    .byte_valid (w_accept),
    .byte_in    (byte_i),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  assign w_len_ok    = (w_word != 32'd0) && (w_word <= DEPTH_W);
  assign w_data_word = (r_state == ST_DATA) && w_word_valid;
  assign w_last_word = (r_word_cnt + 32'd1) == r_len;
  assign w_csum_ok   = (w_word == r_sum);

  // Inter-byte idle counter; only meaningful while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (!w_busy || w_accept || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  // Frame sequencing: length check, payload count, checksum verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            r_state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
          end else if (w_word_valid) begin
            r_len   <= w_word;
            r_state <= w_len_ok ? ST_DATA : ST_ERR;
          end
        end
        ST_DATA: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
          end else if (w_word_valid && w_last_word) begin
            r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
          end else if (w_word_valid) begin
            r_state <= w_csum_ok ? ST_DONE : ST_ERR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ROM write port: one-cycle strobe, address/data held until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      r_next_addr <= '0;
    end else begin
      we_o <= w_data_word;
      if (w_start) begin
        r_next_addr <= ADDR_BASE;
      end else if (w_data_word) begin
        addr_o      <= r_next_addr;
        data_o      <= w_word;
        r_next_addr <= r_next_addr + 32'd4;
      end
    end
  end

  // Word count and running checksum, restarted with each new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_sum      <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
      r_sum      <= '0;
    end else if (w_data_word) begin
      r_word_cnt <= r_word_cnt + 32'd1;
      r_sum      <= r_sum + w_word;
    end
  end

  // CPU hold: raised when a load starts, released only by a good checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_hold <= 1'b0;
    end else if (w_start) begin
      r_cpu_hold <= 1'b1;
    end else if ((r_state == ST_CSUM) && w_word_valid && w_csum_ok) begin
      r_cpu_hold <= 1'b0;
    end
  end

  assign byte_ready_o = w_busy;
  assign busy_o       = w_busy;
  assign done_o       = (r_state == ST_DONE);
  assign err_o        = (r_state == ST_ERR);
  assign cpu_hold_o   = r_cpu_hold;
  assign word_cnt_o   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_loader                                                         |
// | Self-checking bench for rom_loader: directed and random frames        |
// | compared against a frame-level reference model.                       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_rom_loader;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        cpu_hold_o;
  logic [31:0] word_cnt_o;

  int vectors     = 0;
  int miscompares = 0;
  int wr_total    = 0;
  bit poke_start  = 1'b0;

  rom_loader #(
    .DEPTH     (DEPTH),
    .ADDR_BASE (BASE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_hold_o   (cpu_hold_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk = ~clk;

  // Count every cycle the write strobe is seen high.
  always @(negedge clk) begin
    if (we_o === 1'b1) wr_total <= wr_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  // Optional idle gap (random bytes offered with valid low), then one byte.
  task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap);
    int g;
    g = $urandom_range(min_gap, max_gap);
    repeat (g) begin
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
      start_i      = poke_start & 1'($urandom_range(0, 1));
      tick();
    end
    start_i      = 1'b0;
    byte_valid_i = 1'b1;
    byte_i       = b;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int min_gap, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], min_gap, max_gap);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_ready", byte_ready_o, 1);
    check("start_hold", cpu_hold_o, 1);
    check("start_done", done_o, 0);
    check("start_err", err_o, 0);
    check("start_cnt", word_cnt_o, 0);
  endtask

  // Frame-level model: a legal length writes every payload word to
  // BASE+4*i; the verdict is the mod-2^32 sum compared to the checksum.
  task automatic run_frame(input logic [31:0] len, input logic [31:0] words[$],
                           input logic [31:0] csum, input int max_gap);
    logic        len_ok;
    logic [31:0] exp_sum;
    logic        exp_done;
    int          wr0;
    len_ok  = (len >= 1) && (len <= DEPTH);
    exp_sum = '0;
    if (len_ok) for (int i = 0; i < int'(len); i++) exp_sum = exp_sum + words[i];
    exp_done = len_ok && (exp_sum == csum);
    wr0 = wr_total;
    do_start();
    send_word(len, 0, max_gap);
    if (!len_ok) begin
      check("len_err", err_o, 1);
      check("len_busy", busy_o, 0);
      check("len_hold", cpu_hold_o, 1);
      check("len_we", we_o, 0);
      idle(2);
      check("len_writes", 32'(wr_total - wr0), 0);
      return;
    end
    check("len_ok_busy", busy_o, 1);
    for (int i = 0; i < int'(len); i++) begin
      send_word(words[i], 0, max_gap);
      check("wr_we", we_o, 1);
      check("wr_addr", addr_o, BASE + 32'(4 * i));
      check("wr_data", data_o, words[i]);
      check("wr_cnt", word_cnt_o, 32'(i + 1));
    end
    send_word(csum, 0, max_gap);
    check("res_done", done_o, exp_done);
    check("res_err", err_o, !exp_done);
    check("res_hold", cpu_hold_o, !exp_done);
    check("res_busy", busy_o, 0);
    check("res_cnt", word_cnt_o, len);
    idle(2);
    check("res_writes", 32'(wr_total - wr0), len);
    check("res_ready", byte_ready_o, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] len;
    logic [31:0] sum;
    logic [31:0] w;
    int          n;
    int          wr0;

    rst          = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    idle(3);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy_o, 0);
    check("rst_ready", byte_ready_o, 0);
    check("rst_we", we_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_hold", cpu_hold_o, 0);
    check("rst_cnt", word_cnt_o, 0);

    // Bytes offered while idle are dropped
    byte_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_i = 8'($urandom);
      tick();
    end
    idle(2);
    check("idle_writes", 32'(wr_total), 0);
    check("idle_busy", busy_o, 0);
    check("idle_cnt", word_cnt_o, 0);

    // Nominal frame
    q = {32'h0000_0013, 32'hDEAD_BEEF};
    run_frame(32'd2, q, 32'hDEAD_BF02, 2);
    // Bad checksum
    run_frame(32'd2, q, 32'h0000_0000, 2);
    // Illegal lengths
    q = {};
    run_frame(32'd0, q, 32'h0, 1);
    run_frame(32'(DEPTH + 1), q, 32'h0, 1);
    // Checksum wrap
    q = {32'hFFFF_FFFF, 32'h0000_0002};
    run_frame(32'd2, q, 32'h0000_0001, 1);

    // Byte arriving exactly in the would-be timeout cycle is accepted
    w = 32'hC0DE_1234;
    do_start();
    send_word(32'd1, 0, 0);
    send_byte(w[7:0], 0, 0);
    send_byte(w[15:8], TMO - 1, TMO - 1);
    check("edge_err", err_o, 0);
    check("edge_busy", busy_o, 1);
    send_byte(w[23:16], 0, 0);
    send_byte(w[31:24], 0, 0);
    check("edge_we", we_o, 1);
    check("edge_data", data_o, w);
    send_word(w, 0, 0);
    check("edge_done", done_o, 1);

    // Timeout after 6 payload bytes
    wr0 = wr_total;
    w   = 32'h1122_3344;
    do_start();
    send_word(32'd3, 0, 0);
    send_word(w, 0, 0);
    check("to_we", we_o, 1);
    check("to_addr", addr_o, BASE);
    send_byte(8'hAA, 0, 0);
    send_byte(8'hBB, 0, 0);
    n = 0;
    while (err_o !== 1'b1 && n < 4 * TMO) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'(TMO));
    check("to_hold", cpu_hold_o, 1);
    check("to_busy", busy_o, 0);
    check("to_done", done_o, 0);
    check("to_cnt", word_cnt_o, 1);
    idle(2);
    check("to_writes", 32'(wr_total - wr0), 1);

    // Reset mid-DATA, then a fresh frame
    do_start();
    send_word(32'd3, 0, 1);
    send_word(32'hAAAA_5555, 0, 1);
    send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy_o, 0);
    check("mid_hold", cpu_hold_o, 0);
    check("mid_cnt", word_cnt_o, 0);
    check("mid_addr", addr_o, 0);
    check("mid_data", data_o, 0);
    q = {32'h0BAD_F00D};
    run_frame(32'd1, q, 32'h0BAD_F00D, 1);

    // Random frames, with start_i pulsed inside frames
    poke_start = 1'b1;
    for (int f = 0; f < 12; f++) begin
      q = {};
      case ($urandom_range(0, 7))
        0:       len = 32'd0;
        1:       len = 32'(DEPTH + 1) + 32'($urandom_range(0, 1000));
        default: len = 32'($urandom_range(1, 6));
      endcase
      sum = '0;
      if (len <= 6) begin
        for (int i = 0; i < int'(len); i++) begin
          q.push_back($urandom);
          sum = sum + q[i];
        end
      end
      if ($urandom_range(0, 1) == 0) sum = sum ^ (32'd1 << $urandom_range(0, 31));
      run_frame(len, q, sum, 3);
    end
    poke_start = 1'b0;

    // Maximum legal length
    q   = {};
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back($urandom);
      sum = sum + q[i];
    end
    run_frame(32'(DEPTH), q, sum, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
# rom_loader

Boot-time initiator for the instruction ROM's write port. Accepts a framed little-endian byte stream (typically from the UART receiver), assembles it into 32-bit words and drives the ROM's write-enable, address and write-data inputs. It holds the CPU in reset while loading, verifies a trailing checksum, and reports done or error.

## Interface
- `DEPTH`, 4096: ROM capacity in 32-bit words; the maximum legal word count.
- `ADDR_BASE`, 32'h0: byte address of the first word written.
- `TIMEOUT`, 1_000_000: idle cycles allowed between bytes while loading before aborting.

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a load; sampled in IDLE, DONE or ERR.
- `byte_valid_i` in 1: `byte_i` is valid this cycle.
- `byte_i` in 8: stream byte.
- `byte_ready_o` out 1: the loader accepts a byte this cycle; a transfer occurs when valid and ready are both high.
- `we_o` out 1: one-cycle ROM write strobe.
- `addr_o` out 32: ROM byte address; word-aligned, bits [1:0] always 0.
- `data_o` out 32: ROM write data.
- `busy_o` out 1: high in LEN, DATA and CSUM.
- `done_o` out 1: load completed with a good checksum; level signal.
- `err_o` out 1: load aborted; level signal.
- `cpu_hold_o` out 1: holds the CPU in reset.
- `word_cnt_o` out 32: number of words written so far.

## Operation
- Frame format:
  - 4 bytes: word count N, little-endian.
  - 4·N bytes: payload words, each little-endian.
  - 4 bytes: checksum, equal to the sum of all N payload words mod 2^32.
- State machine:
  - IDLE → LEN on `start_i`.
  - LEN → DATA after 4 bytes if 1 ≤ N ≤ DEPTH; otherwise LEN → ERR.
  - DATA → CSUM after 4·N bytes.
  - CSUM → DONE if the checksum matches; otherwise CSUM → ERR.
  - DONE or ERR → LEN on `start_i`. This clears `done_o`/`err_o`, `word_cnt_o` and the running sum.
- Byte assembly: a 2-bit byte index. The byte with index k fills bits [8k+7:8k]. The index wraps 3→0 on each completed word.
- Write address: word i (0-based) is written to `ADDR_BASE` + 4·i. The address is held in a 32-bit register incremented by 4 after each write.
- Running sum: a 32-bit accumulator; overflow wraps silently.
- `cpu_hold_o`: set on entry to LEN, cleared only on entry to DONE; stays high in ERR.
- `byte_ready_o` = `busy_o`; no backpressure inside a frame. Bytes offered in IDLE, DONE or ERR are dropped.
- `start_i` while `busy_o` is high is ignored.
- Timeout: a counter runs while busy and clears on every accepted byte. When it reaches `TIMEOUT` the state goes to ERR and any partial word is discarded unwritten.

## Timing
- Reset values: state IDLE; all outputs 0, including `addr_o`, `data_o` and `word_cnt_o`. `rst` mid-load returns to IDLE immediately; the ROM keeps any words already written.
- Byte throughput: 1 byte per cycle maximum.
- Write latency: `we_o` is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - `addr_o`/`data_o` are valid in that same cycle and held until the next write.
  - `word_cnt_o` increments in that cycle.
- DATA → CSUM: the transition happens in the cycle after the last payload byte, aligned with the final `we_o`.
- Checksum result: `done_o` or `err_o` rises the cycle after the 4th checksum byte is accepted; `cpu_hold_o` falls in the same cycle as `done_o` rises.
- Length error: `err_o` rises the cycle after the 4th length byte; no write occurs.
- Simultaneous events: a byte arriving in the same cycle the timeout expires is accepted, and the timeout does not fire.

## Structure
- Shared package `rom_loader_pkg`: state enum (IDLE, LEN, DATA, CSUM, DONE, ERR) and the frame header/checksum byte-count constant (4).
- Sub-module `byte_packer`: 4-byte to 32-bit little-endian assembler with byte index, `word_valid` pulse and synchronous clear.
- The FSM, counters and checksum stay in `rom_loader`.

## Test plan
- Nominal load, N=2, words 32'h00000013, 32'hDEADBEEF, checksum 32'hDEADBF02, `ADDR_BASE`=0 → `we_o` at 0x0 then 0x4 with those data values; then `done_o`=1, `cpu_hold_o`=0, `word_cnt_o`=2.
- Bad checksum, same frame with checksum 32'h0 → two writes occur, then `err_o`=1, `cpu_hold_o`=1, `done_o`=0.
- Length N=0 and N=4097 → `err_o` the cycle after the 4th length byte; `we_o` never asserts.
- Timeout with `TIMEOUT`=16: stop after 6 payload bytes → `err_o` after 16 idle cycles; exactly 1 write occurred.
- Reset mid-DATA, then `start_i` plus a fresh N=1 frame → the first write goes to `ADDR_BASE`, `word_cnt_o` ends at 1, `done_o`=1.
- Checksum wrap, N=2, words 32'hFFFFFFFF and 32'h00000002, checksum 32'h00000001 → `done_o`=1.
